// File: rtl/ysyx_23060236_reverse_lut.sv
// Reverse lookup table: stores {valid, key, data} entries and searches data back to key.
// Define YSYX_23060236_REVERSE_LUT_PARALLEL_EN to compare every entry in one SCAN cycle.
module ysyx_23060236_reverse_lut #(
    parameter int NR_ENTRY = 4,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 32,
    parameter int IDX_LEN  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_LEN-1:0] req_data,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [KEY_LEN-1:0]  resp_key,
    output logic [IDX_LEN-1:0]  resp_idx,
    output logic [1:0]          o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the producer holds valid and payload stable until that edge.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [NR_ENTRY-1:0]   r_valid;
    logic [KEY_LEN-1:0]    r_key  [NR_ENTRY];
    logic [DATA_LEN-1:0]   r_data [NR_ENTRY];

    logic [DATA_LEN-1:0]   r_req_data;
    logic [IDX_LEN-1:0]    r_scan_idx;
    logic                  r_hit;
    logic [KEY_LEN-1:0]    r_key_out;
    logic [IDX_LEN-1:0]    r_idx_out;

    logic                  w_match;
    logic [IDX_LEN-1:0]    w_match_idx;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_done;

`ifdef YSYX_23060236_REVERSE_LUT_PARALLEL_EN
    // Walk from the top down so the lowest matching index is the one left standing.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_last      = 1'b1;
        for (int i = NR_ENTRY - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_data[i] == r_req_data)) begin
                w_match     = 1'b1;
                w_match_idx = IDX_LEN'(i);
            end
        end
    end
`else
    always_comb begin
        w_match     = r_valid[r_scan_idx] && (r_data[r_scan_idx] == r_req_data);
        w_match_idx = r_scan_idx;
        w_last      = (r_scan_idx == IDX_LEN'(NR_ENTRY - 1));
    end
`endif

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_match || w_last) begin
                    w_done       = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Table storage; comparisons read the registered contents, so a same-cycle write is not seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < NR_ENTRY; i++) begin
                r_key[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_idx] <= 1'b1;
            r_key[wr_idx]   <= wr_key;
            r_data[wr_idx]  <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req_data <= '0;
            r_scan_idx <= '0;
            r_hit      <= 1'b0;
            r_key_out  <= '0;
            r_idx_out  <= '0;
        end else begin
            if (w_accept) begin
                r_req_data <= req_data;
                r_scan_idx <= '0;
            end else if (r_state == S_SCAN && !w_done) begin
                r_scan_idx <= r_scan_idx + 1'b1;
            end
            if (w_done) begin
                r_hit     <= w_match;
                r_key_out <= w_match ? r_key[w_match_idx] : '0;
                r_idx_out <= w_match ? w_match_idx : '0;
            end
        end
    end

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_hit    = resp_valid & r_hit;
    assign resp_key    = resp_valid ? r_key_out : '0;
    assign resp_idx    = resp_valid ? r_idx_out : '0;
    assign o_dbg_state = r_state;

endmodule

// File: doc/ysyx_23060236_reverse_lut.md
YSYX_23060236_REVERSE_LUT -- requirements
Module: ysyx_23060236_reverse_lut

Interface
REQ-001 SHALL have parameter NR_ENTRY, default 4, number of stored key/data pairs (power of two, >= 2).
REQ-002 SHALL have parameter KEY_LEN, default 8, key width.
REQ-003 SHALL have parameter DATA_LEN, default 32, data width.
REQ-004 SHALL have parameter IDX_LEN, default 2, entry index width, equal to log2(NR_ENTRY).
REQ-005 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write one entry this cycle.
REQ-008 SHALL have port wr_idx  input  IDX_LEN  entry to write.
REQ-009 SHALL have ports wr_key  input  KEY_LEN and wr_data  input  DATA_LEN  pair to store.
REQ-010 SHALL have port flush  input  1  invalidate all entries.
REQ-011 SHALL have ports req_valid  input  1, req_ready  output  1, req_data  input  DATA_LEN  search request channel.
REQ-012 SHALL have ports resp_valid  output  1, resp_ready  input  1  response channel.
REQ-013 SHALL have ports resp_hit  output  1, resp_key  output  KEY_LEN, resp_idx  output  IDX_LEN  search result.

Function
REQ-014 SHALL store NR_ENTRY entries, each {valid, key, data}; a search maps data back to key (the inverse of the key-to-data mux).
REQ-015 SHALL, on wr_en, write wr_key/wr_data into entry wr_idx and set its valid bit at the clock edge.
REQ-016 SHALL, on flush, clear all valid bits; flush has priority over wr_en in the same cycle.
REQ-017 SHALL implement FSM states IDLE, SCAN, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; req_valid&&req_ready in cycle T latches req_data, clears the scan index to 0 and enters SCAN.
REQ-019 SHALL, in SCAN, compare one entry per cycle in ascending index order; an entry matches only if valid and data equals the latched req_data.
REQ-020 SHALL, on a match at entry i, capture hit=1, key, and idx=i, and enter RESP; resp_valid is first high in cycle T+2+i.
REQ-021 SHALL, with no match after entry NR_ENTRY-1, capture hit=0, key=0, idx=0 and enter RESP; resp_valid is first high in cycle T+1+NR_ENTRY.
REQ-022 SHALL report the lowest matching index when several entries match.
REQ-023 SHALL hold resp_valid and all resp_* outputs stable in RESP until resp_ready=1, then return to IDLE at that edge.
REQ-024 SHALL compare against pre-write contents when a write or flush targets the entry being compared in the same cycle; writes and flushes are accepted in every state.
REQ-025 SHALL keep resp_hit, resp_key and resp_idx at 0 whenever resp_valid=0.

Reset
REQ-026 SHALL, on reset assertion (asynchronous, regardless of clock), clear all valid bits, enter IDLE, and set the scan index to 0.
REQ-027 SHALL set output reset values: req_ready=1 after release (IDLE); resp_valid=0; resp_hit=0; resp_key=0; resp_idx=0.
REQ-028 SHALL abort an in-flight search on reset mid-SCAN or mid-RESP with no response produced.

Configuration
REQ-029 SHALL, with macro YSYX_23060236_REVERSE_LUT_PARALLEL_EN defined, compare all entries in the single SCAN cycle (lowest index wins); resp_valid is then always first high in cycle T+2.
REQ-030 SHALL, without YSYX_23060236_REVERSE_LUT_PARALLEL_EN, use the sequential one-entry-per-cycle scan of REQ-019..REQ-021.

Verification
REQ-031 SHALL cover: write idx2 {key=8'h5A, data=32'hDEADBEEF}, search 32'hDEADBEEF accepted at T -> resp_valid at T+4 (sequential) or T+2 (parallel), hit=1, key=8'h5A, idx=2.
REQ-032 SHALL cover: search 32'h12345678 with no matching entry -> resp_valid at T+5 (NR_ENTRY=4), hit=0, key=0, idx=0.
REQ-033 SHALL cover: entries 1 and 3 both hold 32'hCAFE0000 with keys 8'h11 and 8'h33 -> hit=1, key=8'h11, idx=1.
REQ-034 SHALL cover: resp_ready held 0 for 3 cycles -> resp_* stable, req_ready=0, and a new request is accepted only after the handshake completes.
REQ-035 SHALL cover: flush asserted together with wr_en to idx0, then search for that data -> hit=0.
REQ-036 SHALL cover: reset pulsed mid-SCAN -> resp_valid stays 0, all entries invalid, FSM in IDLE with req_ready=1 after release.
